// File: rtl/signed_vedic_pkg.sv
// Shared widths, FSM state type and the operand magnitude helper for the signed vedic MAC.
package signed_vedic_pkg;

  localparam int OP_W   = 9;
  localparam int MAG_W  = 9;
  localparam int PMAG_W = 17;
  localparam int PROD_W = 18;

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  // |-256| = 256 fits in 9 unsigned bits, so no saturation is needed.
  function automatic logic [MAG_W-1:0] abs9(input logic [OP_W-1:0] x);
    return x[OP_W-1] ? (~x + 9'd1) : x;
  endfunction

endpackage

// File: rtl/signed_vedic_mac_if.sv
// Operand input stream and frame-result output stream of the signed vedic MAC.
interface signed_vedic_mac_if #(
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 64
);
  import signed_vedic_pkg::*;

  localparam int TERM_W = $clog2(MAX_TERMS + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [OP_W-1:0]   in_a;
  logic signed [OP_W-1:0]   in_b;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_acc;
  logic [TERM_W-1:0]        out_terms;
  logic                     out_ovf;
  logic                     out_forced;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_terms, out_ovf, out_forced
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_terms, out_ovf, out_forced
  );

endinterface

// File: rtl/vedic_8X8.sv
// Unsigned 8x8 combinational vedic multiplier: 2x2 cells -> 4x4 blocks -> 8x8 result.
module vedic_8X8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  function automatic logic [3:0] v2x2(input logic [1:0] x, input logic [1:0] y);
    logic c;
    c = (x[1] & y[0]) & (x[0] & y[1]);
    return {(x[1] & y[1]) & c, (x[1] & y[1]) ^ c, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
  endfunction

  function automatic logic [7:0] v4x4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] ll, lh, hl, hh;
    ll = {4'b0, v2x2(x[1:0], y[1:0])};
    lh = {4'b0, v2x2(x[3:2], y[1:0])};
    hl = {4'b0, v2x2(x[1:0], y[3:2])};
    hh = {4'b0, v2x2(x[3:2], y[3:2])};
    return ll + (lh << 2) + (hl << 2) + (hh << 4);
  endfunction

  // pp[gi]: gi[0] selects the nibble of a, gi[1] the nibble of b.
  logic [7:0] pp [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      assign pp[gi] = v4x4(a[4*(gi%2) +: 4], b[4*(gi/2) +: 4]);
    end
  endgenerate

  assign p = {8'b0, pp[0]} + ({8'b0, pp[1]} << 4) + ({8'b0, pp[2]} << 4) + ({8'b0, pp[3]} << 8);

endmodule

// File: rtl/signed_vedic_mac.sv
// Three-stage signed multiply-accumulate: one dot-product per frame, result held until taken.
module signed_vedic_mac
  import signed_vedic_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 64
) (
  input  logic                clk,
  input  logic                rst,
  signed_vedic_mac_if.slave   bus
);

  localparam int TERM_W = $clog2(MAX_TERMS + 1);

  state_t              state_reg;
  logic                v1_reg, close1_reg, sign1_reg;
  logic [MAG_W-1:0]    mag_a_reg, mag_b_reg;
  logic                v2_reg, close2_reg, sign2_reg;
  logic [PMAG_W-1:0]   pmag_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic [TERM_W-1:0]   count_reg;
  logic                ovf_reg, forced_reg;

  logic                out_valid_reg, out_ovf_reg, out_forced_reg;
  logic signed [ACC_W-1:0] out_acc_reg;
  logic [TERM_W-1:0]   out_terms_reg;

  logic                accept, close_now;
  logic [TERM_W-1:0]   count_next;
  logic [15:0]         core_p;
  logic [PMAG_W-1:0]   pmag_next;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  addend, sum;
  logic                ovf_add;

  assign bus.in_ready   = (state_reg == ACCUM);
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_acc    = out_acc_reg;
  assign bus.out_terms  = out_terms_reg;
  assign bus.out_ovf    = out_ovf_reg;
  assign bus.out_forced = out_forced_reg;

  assign accept     = bus.in_valid && bus.in_ready;
  assign count_next = count_reg + 1'b1;
  assign close_now  = accept && (bus.in_last || (count_next == TERM_W'(MAX_TERMS)));

  vedic_8X8 u_core (
    .a (mag_a_reg[7:0]),
    .b (mag_b_reg[7:0]),
    .p (core_p)
  );

  // Magnitude 256 only occurs for -256, so that case reduces to a shift.
  always_comb begin
    pmag_next = {1'b0, core_p};
    case ({mag_a_reg[MAG_W-1], mag_b_reg[MAG_W-1]})
      2'b10:   pmag_next = {mag_b_reg[7:0], 8'b0} | 17'(mag_b_reg[8]) << 16;
      2'b01:   pmag_next = {mag_a_reg[7:0], 8'b0} | 17'(mag_a_reg[8]) << 16;
      2'b11:   pmag_next = 17'h10000;
      default: pmag_next = {1'b0, core_p};
    endcase
  end

  assign prod_s  = sign2_reg ? -$signed({1'b0, pmag_reg}) : $signed({1'b0, pmag_reg});
  assign addend  = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
  assign sum     = acc_reg + addend;
  assign ovf_add = (acc_reg[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc_reg[ACC_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ACCUM;
      v1_reg         <= 1'b0;
      v2_reg         <= 1'b0;
      close1_reg     <= 1'b0;
      close2_reg     <= 1'b0;
      sign1_reg      <= 1'b0;
      sign2_reg      <= 1'b0;
      mag_a_reg      <= '0;
      mag_b_reg      <= '0;
      pmag_reg       <= '0;
      acc_reg        <= '0;
      count_reg      <= '0;
      ovf_reg        <= 1'b0;
      forced_reg     <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_acc_reg    <= '0;
      out_terms_reg  <= '0;
      out_ovf_reg    <= 1'b0;
      out_forced_reg <= 1'b0;
    end else begin
      v1_reg <= accept;
      if (accept) begin
        sign1_reg  <= bus.in_a[OP_W-1] ^ bus.in_b[OP_W-1];
        mag_a_reg  <= abs9(bus.in_a);
        mag_b_reg  <= abs9(bus.in_b);
        close1_reg <= close_now;
        count_reg  <= count_next;
        if (close_now) forced_reg <= !bus.in_last;
      end

      v2_reg     <= v1_reg;
      close2_reg <= close1_reg;
      sign2_reg  <= sign1_reg;
      pmag_reg   <= pmag_next;

      if (v2_reg) begin
        acc_reg <= sum;
        ovf_reg <= ovf_reg | ovf_add;
      end

      case (state_reg)
        ACCUM: if (close_now) state_reg <= DRAIN;
        DRAIN: begin
          if (v2_reg && close2_reg) begin
            out_acc_reg    <= sum;
            out_terms_reg  <= count_reg;
            out_ovf_reg    <= ovf_reg | ovf_add;
            out_forced_reg <= forced_reg;
            out_valid_reg  <= 1'b1;
            state_reg      <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
            count_reg     <= '0;
            ovf_reg       <= 1'b0;
            forced_reg    <= 1'b0;
            state_reg     <= ACCUM;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_vedic_mac.sv
// Directed bench for signed_vedic_mac: vector table of frames plus hand-written multi-cycle cases.
module tb_signed_vedic_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  signed_vedic_mac_if #(.ACC_W(24), .MAX_TERMS(64)) u ();
  signed_vedic_mac_if #(.ACC_W(18), .MAX_TERMS(64)) v ();

  signed_vedic_mac #(.ACC_W(24), .MAX_TERMS(64)) dut (.clk(clk), .rst(rst), .bus(u));
  signed_vedic_mac #(.ACC_W(18), .MAX_TERMS(64)) dut18 (.clk(clk), .rst(rst), .bus(v));

  typedef struct {
    int     n;
    int     a[4];
    int     b[4];
    longint acc;
    int     terms;
  } vec_t;

  vec_t vecs[9];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_term(input int a, input int b, input bit last);
    int w;
    u.in_valid = 1'b1;
    u.in_a     = 9'(a);
    u.in_b     = 9'(b);
    u.in_last  = last;
    w = 0;
    while (!u.in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!u.in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Called just after the closing accept edge; checks latency, result and the handshake.
  task automatic finish_frame(input string name, input longint eacc, input int eterms,
                              input bit eovf, input bit eforced);
    int lat;
    u.in_valid = 1'b0;
    u.in_last  = 1'b0;
    lat = 0;
    while (!u.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, ".latency"}, lat, 2);
    chk({name, ".acc"}, longint'(u.out_acc), eacc);
    chk({name, ".terms"}, u.out_terms, eterms);
    chk({name, ".ovf"}, u.out_ovf, eovf);
    chk({name, ".forced"}, u.out_forced, eforced);
    $display("frame %s: acc=%0d terms=%0d ovf=%0b forced=%0b", name, u.out_acc, u.out_terms,
             u.out_ovf, u.out_forced);
    u.out_ready = 1'b1;
    @(posedge clk); #1;
    u.out_ready = 1'b0;
    chk({name, ".valid_drop"}, u.out_valid, 0);
    chk({name, ".ready_back"}, u.in_ready, 1);
  endtask

  task automatic wait_valid_u(input string name);
    int w;
    w = 0;
    while (!u.out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk({name, ".valid"}, u.out_valid, 1);
  endtask

  initial begin
    vecs[0] = '{3, '{3, -5, 7, 0},        '{4, 6, -8, 0},      -74,    3};
    vecs[1] = '{1, '{-256, 0, 0, 0},      '{-256, 0, 0, 0},    65536,  1};
    vecs[2] = '{1, '{-256, 0, 0, 0},      '{255, 0, 0, 0},     -65280, 1};
    vecs[3] = '{1, '{2, 0, 0, 0},         '{2, 0, 0, 0},       4,      1};
    vecs[4] = '{2, '{255, -1, 0, 0},      '{255, 1, 0, 0},     65024,  2};
    vecs[5] = '{4, '{-256, 100, 0, -7},   '{5, -3, 9, -7},     -1531,  4};
    vecs[6] = '{2, '{170, -99, 0, 0},     '{85, 201, 0, 0},    -5449,  2};
    vecs[7] = '{2, '{-256, -256, 0, 0},   '{-256, -256, 0, 0}, 131072, 2};
    vecs[8] = '{2, '{15, -16, 0, 0},      '{17, -16, 0, 0},    511,    2};

    u.in_valid = 0; u.in_a = '0; u.in_b = '0; u.in_last = 0; u.out_ready = 0;
    v.in_valid = 0; v.in_a = '0; v.in_b = '0; v.in_last = 0; v.out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset.out_valid", u.out_valid, 0);
    chk("reset.out_acc", longint'(u.out_acc), 0);
    chk("reset.out_terms", u.out_terms, 0);
    chk("reset.out_ovf", u.out_ovf, 0);
    chk("reset.out_forced", u.out_forced, 0);
    chk("reset.in_ready", u.in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < vecs[i].n; k++)
        send_term(vecs[i].a[k], vecs[i].b[k], k == vecs[i].n - 1);
      finish_frame($sformatf("vec%0d", i), vecs[i].acc, vecs[i].terms, 1'b0, 1'b0);
    end

    // Narrow accumulator wraps and flags overflow.
    v.in_valid = 1; v.in_a = -9'sd256; v.in_b = -9'sd256; v.in_last = 0;
    @(posedge clk); #1;
    v.in_last = 1;
    @(posedge clk); #1;
    v.in_valid = 0; v.in_last = 0;
    begin
      int w;
      w = 0;
      while (!v.out_valid && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
    end
    chk("acc18.valid", v.out_valid, 1);
    chk("acc18.acc", longint'(v.out_acc), -131072);
    chk("acc18.ovf", v.out_ovf, 1);
    chk("acc18.terms", v.out_terms, 2);
    $display("frame acc18: acc=%0d terms=%0d ovf=%0b", v.out_acc, v.out_terms, v.out_ovf);
    v.out_ready = 1;
    @(posedge clk); #1;
    v.out_ready = 0;
    chk("acc18.valid_drop", v.out_valid, 0);

    // 64 terms without in_last: force-closed, 65th pair held off until handshake.
    for (int k = 0; k < 64; k++) send_term(1, 1, 1'b0);
    u.in_valid = 1; u.in_a = 9'sd9; u.in_b = 9'sd9; u.in_last = 1;
    begin
      int w;
      int ready_seen;
      w = 0;
      ready_seen = 0;
      while (!u.out_valid && w < 20) begin
        if (u.in_ready) ready_seen++;
        @(posedge clk); #1;
        w++;
      end
      chk("forced.latency", w, 2);
      chk("forced.ready_low", ready_seen, 0);
    end
    chk("forced.acc", longint'(u.out_acc), 64);
    chk("forced.terms", u.out_terms, 64);
    chk("forced.forced", u.out_forced, 1);
    chk("forced.in_ready", u.in_ready, 0);
    $display("frame forced: acc=%0d terms=%0d forced=%0b", u.out_acc, u.out_terms, u.out_forced);
    u.out_ready = 1;
    @(posedge clk); #1;
    u.out_ready = 0;
    chk("forced.ready_after", u.in_ready, 1);
    @(posedge clk); #1;
    finish_frame("after_forced", 81, 1, 1'b0, 1'b0);

    // in_last on the 64th term is a normal close.
    for (int k = 0; k < 64; k++) send_term(1, 1, k == 63);
    finish_frame("last64", 64, 64, 1'b0, 1'b0);

    // Backpressure in HOLD.
    send_term(2, 3, 1'b1);
    u.in_valid = 0; u.in_last = 0;
    wait_valid_u("bp");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.hold%0d.valid", k), u.out_valid, 1);
      chk($sformatf("bp.hold%0d.acc", k), longint'(u.out_acc), 6);
      chk($sformatf("bp.hold%0d.in_ready", k), u.in_ready, 0);
    end
    u.out_ready = 1;
    @(posedge clk); #1;
    u.out_ready = 0;
    chk("bp.valid_drop", u.out_valid, 0);
    chk("bp.ready_back", u.in_ready, 1);
    chk("bp.acc_held", longint'(u.out_acc), 6);
    $display("frame bp: acc=%0d after 5 held cycles", u.out_acc);

    // Reset mid-frame after two terms.
    send_term(10, 10, 1'b0);
    send_term(20, 20, 1'b0);
    u.in_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_mid.out_acc", longint'(u.out_acc), 0);
    chk("rst_mid.in_ready", u.in_ready, 1);
    repeat (4) @(posedge clk);
    #1 chk("rst_mid.no_valid", u.out_valid, 0);
    send_term(2, 2, 1'b1);
    finish_frame("rst_mid_next", 4, 1, 1'b0, 1'b0);

    // Reset during DRAIN.
    send_term(5, 5, 1'b1);
    u.in_valid = 0; u.in_last = 0;
    chk("rst_drain.in_ready", u.in_ready, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    repeat (4) @(posedge clk);
    #1 chk("rst_drain.no_valid", u.out_valid, 0);
    chk("rst_drain.in_ready_back", u.in_ready, 1);
    send_term(2, 2, 1'b1);
    finish_frame("rst_drain_next", 4, 1, 1'b0, 1'b0);

    // Reset during HOLD.
    send_term(-7, 9, 1'b1);
    u.in_valid = 0; u.in_last = 0;
    wait_valid_u("rst_hold");
    chk("rst_hold.acc_before", longint'(u.out_acc), -63);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_hold.valid", u.out_valid, 0);
    chk("rst_hold.acc", longint'(u.out_acc), 0);
    chk("rst_hold.terms", u.out_terms, 0);
    chk("rst_hold.in_ready", u.in_ready, 1);
    send_term(2, 2, 1'b1);
    finish_frame("rst_hold_next", 4, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1);
  end

endmodule

// File: doc/signed_vedic_mac.md
Name: signed_vedic_mac

Overview:
- Pipelined signed multiply-accumulate stage built around the existing unsigned vedic_8X8 core.
- Takes a stream of 9-bit two's-complement operand pairs over a valid/ready handshake and accumulates their products into one dot-product per frame.
- Emits each frame's sum on a valid/ready output.
- Sits directly downstream of the operand source and upstream of the filter/result consumer; replaces per-sample use of the combinational signed multiplier.

Parameters:
ACC_W, 24, accumulator and result width in bits; legal range 18..40.
MAX_TERMS, 64, maximum products per frame; a frame is force-closed on the MAX_TERMS-th term.

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  reset, synchronous and active-high
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts a pair this cycle
in_a  in  9  signed operand A
in_b  in  9  signed operand B
in_last  in  1  this pair is the final term of the frame
out_valid  out  1  frame result valid
out_ready  in  1  consumer accepts the result
out_acc  out  ACC_W  signed frame sum
out_terms  out  $clog2(MAX_TERMS+1)  number of terms summed
out_ovf  out  1  signed overflow occurred in this frame (sticky per frame)
out_forced  out  1  frame closed by MAX_TERMS, not by in_last

Behaviour:
- Reset (rst=1 at a clock edge):
  - state <= ACCUM.
  - All pipeline valids cleared; accumulator, term counter and ovf cleared.
  - Outputs: out_valid=0, out_acc=0, out_terms=0, out_ovf=0, out_forced=0. in_ready=1 from the first cycle after reset.
  - A frame in progress is discarded; no partial result is emitted.
- Accept condition: in_valid && in_ready. in_ready = (state==ACCUM).
- Pipeline, 3 stages:
  - S1 (accept edge): register sign = a[8]^b[8], plus 9-bit magnitudes |a| and |b|. Note |-256| = 256, so mag[8] is set only for -256.
  - S2: 17-bit product magnitude.
    - Neither mag[8] set: vedic_8X8(mag_a[7:0], mag_b[7:0]).
    - Only mag_a[8] set: {mag_b, 8'b0}.
    - Only mag_b[8] set: {mag_a, 8'b0}.
    - Both set: 17'h10000 (65536).
  - S3: sign-extend to ACC_W, negate if sign, then acc <= acc + p.
    - Overflow is set when both addends have the same sign and the sum's sign differs.
    - The accumulator wraps two's-complement.
    - ovf is sticky until frame end.
- Term counter increments on each accept.
- An accept with in_last=1, or the accept that makes the count reach MAX_TERMS, closes the frame. A close with in_last=0 records forced=1; in_last on the MAX_TERMS-th term gives forced=0.
- FSM:
  - ACCUM: accept pairs. On the closing accept -> DRAIN.
  - DRAIN: in_ready=0. Wait until the closing term has been added in S3.
    - If the closing accept is at cycle T, the add happens at edge T+2.
    - At that edge, load out_acc/out_terms/out_ovf/out_forced -> HOLD.
    - out_valid=1 from cycle T+3.
  - HOLD: out_valid=1; out_* stable while out_ready=0.
    - On out_valid && out_ready -> ACCUM.
    - Accumulator, counter, ovf and forced are cleared that edge; in_ready=1 the next cycle.
    - out_ready high on the first HOLD cycle completes the handshake in that cycle.
- Throughput: one pair per cycle within a frame; 4-cycle minimum gap between frames.
- out_valid is never asserted without a completed frame, so empty frames are impossible.
- in_a/in_b/in_last are ignored when not accepted.
- After handshake, out_* hold their last values while out_valid=0; consumers must qualify with out_valid.

Decomposition:
- Package signed_vedic_pkg: OP_W=9, MAG_W=9, PMAG_W=17, PROD_W=18; state enum {ACCUM, DRAIN, HOLD}.
- Function abs9: 9-bit two's-complement to magnitude.
- One sub-module: the existing vedic_8X8 unsigned core, instantiated once in S2.
- Everything else stays inline.

Test Plan:
- Frame (3,4), (-5,6), (7,-8, last) back-to-back -> out_acc=-74, out_terms=3, ovf=0, forced=0; out_valid 3 cycles after the last accept.
- Single term (-256,-256, last), then (-256,255, last) -> out_acc=65536, then -65280; terms=1 each.
- ACC_W=18: (-256,-256), (-256,-256, last) -> out_ovf=1, out_acc=-131072 (wrapped).
- 64 pairs of (1,1), in_last never set -> out_acc=64, out_terms=64, out_forced=1; the 65th pair is held off (in_ready=0) until the handshake.
- Backpressure: out_ready low for 5 cycles in HOLD -> out_* stable, in_ready=0 throughout; accept -> in_ready=1 the next cycle; out_ready high on the first HOLD cycle also completes in one cycle.
- rst asserted for 1 cycle after 2 terms of a frame, in DRAIN, and in HOLD -> all outputs 0, no result emitted; next frame (2,2, last) -> out_acc=4, terms=1.
